// File: rtl/fpu_result_buffer.sv
`default_nettype none
// ============================================================================
// fpu_result_buffer: first-word-fall-through FIFO of FPU {flags,result} with
// end-of-message tracking and sticky detection of results dropped when full.
// Rev 1.0
// ============================================================================
module fpu_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_result,
  input  logic [FLAG_WIDTH-1:0]            in_flags,
  input  logic                             in_eom,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [FLAG_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic                             out_eom,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH):0]           count,
  output logic [CNT_WIDTH-1:0]             txn_count,
  output logic                             overflow_err,
  output logic                             drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = FLAG_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW:0]          mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] txn_q, txn_d;
  logic                 ovf_q, ovf_d;
  logic                 empty, full, push, pop;
  logic [PW:0]          head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign in_ready     = reset && (state_q == ST_RUN) && !full;
  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : head[PW-1:0];
  assign out_eom      = !empty && head[PW];
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign txn_count    = txn_q;
  assign overflow_err = ovf_q;
  assign drained      = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    txn_d    = txn_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    ovf_d    = ovf_q | (in_valid && !in_ready);
    case (state_q)
      ST_RUN:   if (push && in_eom) state_d = ST_FLUSH;
      ST_FLUSH: if (pop && out_eom) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      txn_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      txn_q    <= txn_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: its contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_eom, in_flags, in_result};
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_buffer.sv
`default_nettype none
// ============================================================================
// tb_fpu_result_buffer: directed plus randomized checks against a queue model.
// Rev 1.0
// ============================================================================
module tb_fpu_result_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = '0;
  logic [7:0]  in_flags = '0;
  logic        in_eom = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_data;
  logic        out_eom;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic [15:0] txn_count;
  logic        overflow_err;
  logic        drained;

  fpu_result_buffer #(
    .DATA_WIDTH(32), .FLAG_WIDTH(8), .DEPTH(DEPTH), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_flags(in_flags), .in_eom(in_eom), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eom(out_eom),
    .out_ready(out_ready), .count(count), .txn_count(txn_count),
    .overflow_err(overflow_err), .drained(drained)
  );

  always #5 clk = ~clk;

  // Reference model: message phase, a queue of {eom,flags,result}, counters.
  localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;
  logic [40:0] mq[$];
  int          m_phase = M_RUN;
  logic        m_ovf = 1'b0;
  int unsigned m_txn = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic rst_n);
    return rst_n && (m_phase == M_RUN) && (mq.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    logic [40:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 41'd0;
    chk("in_ready",  {63'd0, in_ready},  {63'd0, model_ready(reset)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("out_data",  {24'd0, out_data},  {24'd0, hd[39:0]});
    chk("out_eom",   {63'd0, out_eom},   {63'd0, hd[40]});
    chk("count",     {60'd0, count},     64'(mq.size()));
    chk("txn_count", {48'd0, txn_count}, {48'd0, m_txn[15:0]});
    chk("ovf",       {63'd0, overflow_err}, {63'd0, m_ovf});
    chk("drained",   {63'd0, drained},   {63'd0, m_phase == M_DONE});
  endtask

  // Apply one cycle of inputs, check current outputs, then advance model.
  task automatic cycle(input logic rst_n, input logic v, input logic [31:0] res,
                       input logic [7:0] fl, input logic eom, input logic ordy);
    logic        rdy, push, pop;
    logic [40:0] hd;
    reset = rst_n; in_valid = v; in_result = res; in_flags = fl;
    in_eom = eom; out_ready = ordy;
    #1;
    check_outputs();
    rdy  = model_ready(rst_n);
    push = v && rdy;
    pop  = (mq.size() > 0) && ordy;
    @(posedge clk); #1;
    if (!rst_n) begin
      mq.delete(); m_phase = M_RUN; m_ovf = 1'b0; m_txn = 0;
    end else begin
      if (v && !rdy) m_ovf = 1'b1;
      if (pop) begin
        hd = mq.pop_front();
        m_txn++;
        if (hd[40]) m_phase = M_DONE;
      end
      if (push) begin
        mq.push_back({eom, fl, res});
        if (eom) m_phase = M_FLUSH;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1, 32'hDEAD, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hDEAD, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with in_valid active.
    @(posedge clk); #1;
    do_reset();
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_ovf",   {63'd0, overflow_err}, 64'd0);
    chk("rst_rdy",   {63'd0, in_ready}, 64'd0);
    cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);

    // Single transaction.
    cycle(1'b1, 1'b1, 32'h3F800000, 8'h02, 1'b0, 1'b1);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_data",  {24'd0, out_data}, 64'h023F800000);
    cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    chk("single_txn",   {48'd0, txn_count}, 64'd1);
    chk("single_count", {60'd0, count}, 64'd0);

    // Fill, partial drain, wrap refill.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 32'(i), 8'h00, 1'b0, 1'b0);
    chk("fill_count", {60'd0, count}, 64'd8);
    chk("fill_rdy",   {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    for (int i = 9; i <= 11; i++) cycle(1'b1, 1'b1, 32'(i), 8'h00, 1'b0, 1'b0);
    chk("wrap_count", {60'd0, count}, 64'd8);
    chk("wrap_head",  {24'd0, out_data}, 64'h4);

    // Overflow while full, then full drain.
    cycle(1'b1, 1'b1, 32'hDEAD, 8'h00, 1'b0, 1'b0);
    chk("ovf_set",   {63'd0, overflow_err}, 64'd1);
    chk("ovf_count", {60'd0, count}, 64'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);

    // Simultaneous push and pop at count 4.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'h51 + 32'(i), 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h55, 8'h00, 1'b0, 1'b1);
    chk("sim_count", {60'd0, count}, 64'd4);
    chk("sim_head",  {24'd0, out_data}, 64'h52);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);

    // End-of-message flow.
    do_reset();
    cycle(1'b1, 1'b1, 32'hA, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'hC, 8'h00, 1'b0, 1'b0);
    chk("eom_rdy",   {63'd0, in_ready}, 64'd0);
    chk("eom_ovf",   {63'd0, overflow_err}, 64'd1);
    chk("eom_count", {60'd0, count}, 64'd2);
    cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    chk("eom_mark",  {63'd0, out_eom}, 64'd1);
    cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    chk("eom_drained", {63'd0, drained}, 64'd1);
    chk("eom_txn",     {48'd0, txn_count}, 64'd2);
    cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("eom_rst_drained", {63'd0, drained}, 64'd0);

    // Randomized traffic with occasional eom and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 149) != 0, $urandom_range(0, 2) != 0, $urandom,
            8'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
